store_buffer: RTL and testbench

- Small in-order FIFO of committed word stores between the MEM stage and data memory.
- Accepts one store per cycle from the MEM stage and drains one store per cycle into the data-memory write port (memWrite/address/writeData).
- Forwards buffered data to loads issued in the same MEM stage, or raises a stall when forwarding is impossible.
- Removes store/load write-port contention and gives the pipeline a single point of memory ordering.

---
 rtl/store_buffer_pkg.sv | 37 +++
 rtl/store_buffer_fwd_match.sv | 38 +++
 rtl/store_buffer.sv | 136 +++++++++++++
 tb/tb_store_buffer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer and the data-memory read path:
// load-size encodings and big-endian byte-lane extraction/extension.
package store_buffer_pkg;

  localparam logic [1:0] LD_NONE   = 2'd0;
  localparam logic [1:0] LD_WORD   = 2'd1;
  localparam logic [1:0] LD_HALF_S = 2'd2;
  localparam logic [1:0] LD_HALF_U = 2'd3;

  localparam int WORD_BYTES = 4;

  // Select the halfword at byte offset 'off' (byte at the lowest address is
  // bits 31:24) and extend it to a word. Word loads pass the word through.
  // An offset of 3 would straddle two words, so it yields zero here.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size);
    logic [15:0] half;
    logic [31:0] result;
    half   = 16'h0000;
    result = 32'h0000_0000;
    case (off)
      2'd0:    half = word[31:16];
      2'd1:    half = word[23:8];
      2'd2:    half = word[15:0];
      default: half = 16'h0000;
    endcase
    case (size)
      LD_WORD:   result = word;
      LD_HALF_S: result = {{16{half[15]}}, half};
      LD_HALF_U: result = {16'h0000, half};
      default:   result = 32'h0000_0000;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/store_buffer_fwd_match.sv
// Overlap and containment compare between one buffered word store and the
// load currently presented by the MEM stage. All range arithmetic wraps
// modulo 2^ADDR_W, so distances are computed as unsigned differences.
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              entry_valid,
  input  logic [ADDR_W-1:0] entry_addr,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [1:0]        ld_size,
  output logic              overlap,
  output logic              contain,
  output logic [1:0]        offset
);

  logic              active;
  logic [ADDR_W-1:0] fwd_dist;
  logic [ADDR_W-1:0] back_dist;
  logic [ADDR_W-1:0] ld_len;
  logic [ADDR_W-1:0] slack;

  // Two ranges on a circle overlap when either start lies inside the other;
  // the load is contained when it starts no later than (4 - len) into the entry.
  always_comb begin
    active    = entry_valid && ld_valid && (ld_size != LD_NONE);
    fwd_dist  = ld_addr - entry_addr;
    back_dist = entry_addr - ld_addr;
    ld_len    = (ld_size == LD_WORD) ? ADDR_W'(WORD_BYTES) : ADDR_W'(2);
    slack     = ADDR_W'(WORD_BYTES) - ld_len;
    overlap   = active && ((fwd_dist < ADDR_W'(WORD_BYTES)) || (back_dist < ld_len));
    contain   = active && (fwd_dist <= slack);
    offset    = fwd_dist[1:0];
  end

endmodule

// File: rtl/store_buffer.sv
// In-order buffer of committed word stores between the MEM stage and the
// data-memory write port. Drains one entry per cycle in FIFO order and
// forwards the youngest overlapping entry to same-cycle loads, or stalls
// the load when the youngest overlapping entry only partly covers it.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [1:0]        ld_size,
  output logic              ld_hit,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_stall,
  output logic              dm_memWrite,
  output logic [ADDR_W-1:0] dm_address,
  output logic [DATA_W-1:0] dm_writeData,
  input  logic              dm_ready,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;

  logic push;
  logic pop;

  // Full blocks new stores even when a drain happens on the same edge.
  assign st_ready     = (count_q != CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign dm_memWrite  = !empty;
  assign dm_address   = empty ? '0 : addr_q[head_q];
  assign dm_writeData = empty ? '0 : data_q[head_q];

  assign push = st_valid && st_ready;
  assign pop  = dm_memWrite && dm_ready;

  // Pointer and occupancy update; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage written at the tail on an accepted store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (push) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
    end
  end

  logic [DEPTH-1:0] slot_valid;
  logic [DEPTH-1:0] slot_overlap;
  logic [DEPTH-1:0] slot_contain;
  logic [1:0]       slot_offset [DEPTH];

  // A physical slot holds a live entry when its age behind head is below count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    logic [PTR_W-1:0] age;
    assign age           = PTR_W'(g) - head_q;
    assign slot_valid[g] = ({1'b0, age} < count_q);

    sb_fwd_match #(
      .ADDR_W (ADDR_W)
    ) u_match (
      .entry_valid (slot_valid[g]),
      .entry_addr  (addr_q[g]),
      .ld_valid    (ld_valid),
      .ld_addr     (ld_addr),
      .ld_size     (ld_size),
      .overlap     (slot_overlap[g]),
      .contain     (slot_contain[g]),
      .offset      (slot_offset[g])
    );
  end

  logic             found;
  logic [PTR_W-1:0] sel;
  logic [PTR_W-1:0] slot;

  // Walk from oldest to youngest so the last overlapping entry seen wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    slot  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_q + PTR_W'(i);
      if (slot_overlap[slot]) begin
        found = 1'b1;
        sel   = slot;
      end
    end
  end

  // Hit when the youngest overlap covers the load, stall when it only partly does.
  always_comb begin
    ld_hit   = found && slot_contain[sel];
    ld_stall = found && !slot_contain[sel];
    ld_data  = '0;
    if (ld_hit) begin
      ld_data = load_extract(data_q[sel], slot_offset[sel], ld_size);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer. Stimulus pushes expected memory writes and
// expected load responses into queues; two monitors pop and compare them on
// the falling edge whenever the DUT presents a write or a load is presented.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              st_valid = 1'b0;
  logic [ADDR_W-1:0] st_addr = '0;
  logic [DATA_W-1:0] st_data = '0;
  logic              st_ready;
  logic              ld_valid = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [1:0]        ld_size = LD_NONE;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;
  logic              ld_stall;
  logic              dm_memWrite;
  logic [ADDR_W-1:0] dm_address;
  logic [DATA_W-1:0] dm_writeData;
  logic              dm_ready = 1'b0;
  logic              empty;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid     (st_valid),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_ready     (st_ready),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_size      (ld_size),
    .ld_hit       (ld_hit),
    .ld_data      (ld_data),
    .ld_stall     (ld_stall),
    .dm_memWrite  (dm_memWrite),
    .dm_address   (dm_address),
    .dm_writeData (dm_writeData),
    .dm_ready     (dm_ready),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic        hit;
    logic        stall;
    logic [31:0] data;
  } ld_t;

  wr_t exp_wr[$];
  ld_t exp_ld[$];
  wr_t wr_e;
  ld_t ld_e;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit will_drain);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    if (will_drain) exp_wr.push_back(wr_t'({a, d}));
    step();
    st_valid = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] size,
                         input logic hit, input logic stall, input logic [31:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_size  = size;
    exp_ld.push_back(ld_t'({hit, stall, d}));
    step();
    ld_valid = 1'b0;
    ld_size  = LD_NONE;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    dm_ready = 1'b1;
    while (!empty && n < 50) begin
      step();
      n++;
    end
    chk("drain_done", {31'b0, empty}, 32'd1);
  endtask

  // Write monitor: every write the memory will accept must match the next expected store.
  always @(negedge clk) begin
    if (rst_n && dm_memWrite && dm_ready) begin
      if (exp_wr.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write",
                 dm_address, dm_writeData);
      end else begin
        wr_e = exp_wr.pop_front();
        chk("wr_addr", dm_address, wr_e.addr);
        chk("wr_data", dm_writeData, wr_e.data);
      end
    end
  end

  // Load monitor: each cycle with a presented load is checked against the next expectation.
  always @(negedge clk) begin
    if (rst_n && ld_valid) begin
      if (exp_ld.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_load: got hit %0b stall %0b expected no load", ld_hit, ld_stall);
      end else begin
        ld_e = exp_ld.pop_front();
        chk("ld_hit", {31'b0, ld_hit}, {31'b0, ld_e.hit});
        chk("ld_stall", {31'b0, ld_stall}, {31'b0, ld_e.stall});
        if (ld_e.hit) chk("ld_data", ld_data, ld_e.data);
      end
    end
  end

  initial begin
    // reset values
    #3;
    chk("rst_st_ready", {31'b0, st_ready}, 32'd1);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_memwrite", {31'b0, dm_memWrite}, 32'd0);
    chk("rst_ld_hit", {31'b0, ld_hit}, 32'd0);
    chk("rst_ld_stall", {31'b0, ld_stall}, 32'd0);
    chk("rst_dm_address", dm_address, 32'd0);
    chk("rst_dm_wdata", dm_writeData, 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // reset in the middle of operation discards pending stores
    dm_ready = 1'b0;
    do_store(32'h0000_0200, 32'hAAAA_0001, 1'b0);
    do_store(32'h0000_0204, 32'hAAAA_0002, 1'b0);
    do_store(32'h0000_0208, 32'hAAAA_0003, 1'b0);
    chk("pre_rst_memwrite", {31'b0, dm_memWrite}, 32'd1);
    chk("pre_rst_address", dm_address, 32'h0000_0200);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_empty", {31'b0, empty}, 32'd1);
    chk("mid_rst_memwrite", {31'b0, dm_memWrite}, 32'd0);
    dm_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    chk("post_rst_empty", {31'b0, empty}, 32'd1);

    // fill with memory busy, then a held fifth store
    dm_ready = 1'b0;
    do_store(32'h0000_0010, 32'hA000_0010, 1'b1);
    do_store(32'h0000_0014, 32'hA000_0014, 1'b1);
    do_store(32'h0000_0018, 32'hA000_0018, 1'b1);
    chk("fill3_st_ready", {31'b0, st_ready}, 32'd1);
    do_store(32'h0000_001C, 32'hA000_001C, 1'b1);
    chk("full_st_ready", {31'b0, st_ready}, 32'd0);
    chk("full_head_addr", dm_address, 32'h0000_0010);
    st_valid = 1'b1;
    st_addr  = 32'h0000_0020;
    st_data  = 32'hA000_0020;
    step();
    chk("held_st_ready", {31'b0, st_ready}, 32'd0);
    chk("held_head_addr", dm_address, 32'h0000_0010);
    dm_ready = 1'b1;
    step();
    chk("after_drain_st_ready", {31'b0, st_ready}, 32'd1);
    exp_wr.push_back(wr_t'({32'h0000_0020, 32'hA000_0020}));
    step();
    st_valid = 1'b0;
    wait_drain();

    // word and halfword forwarding
    dm_ready = 1'b0;
    do_store(32'h0000_0040, 32'hDEAD_BEEF, 1'b1);
    do_load(32'h0000_0040, LD_WORD, 1'b1, 1'b0, 32'hDEAD_BEEF);
    do_store(32'h0000_0040, 32'h12F4_5678, 1'b1);
    do_load(32'h0000_0040, LD_HALF_S, 1'b1, 1'b0, 32'h0000_12F4);
    do_load(32'h0000_0041, LD_HALF_S, 1'b1, 1'b0, 32'hFFFF_F456);
    do_load(32'h0000_0041, LD_HALF_U, 1'b1, 1'b0, 32'h0000_F456);
    do_load(32'h0000_0042, LD_HALF_S, 1'b1, 1'b0, 32'h0000_5678);
    do_load(32'h0000_0040, LD_WORD,   1'b1, 1'b0, 32'h12F4_5678);
    do_load(32'h0000_0043, LD_HALF_U, 1'b0, 1'b1, 32'h0);
    do_load(32'h0000_003E, LD_WORD,   1'b0, 1'b1, 32'h0);
    do_load(32'h0000_003C, LD_WORD,   1'b0, 1'b0, 32'h0);
    do_load(32'h0000_0044, LD_WORD,   1'b0, 1'b0, 32'h0);
    do_load(32'h0000_0040, LD_NONE,   1'b0, 1'b0, 32'h0);

    // partial overlap stalls until both 0x40 entries drain
    do_load(32'h0000_0042, LD_WORD, 1'b0, 1'b1, 32'h0);
    dm_ready = 1'b1;
    do_load(32'h0000_0042, LD_WORD, 1'b0, 1'b1, 32'h0);
    do_load(32'h0000_0042, LD_WORD, 1'b0, 1'b1, 32'h0);
    do_load(32'h0000_0042, LD_WORD, 1'b0, 1'b0, 32'h0);
    chk("overlap_drained_empty", {31'b0, empty}, 32'd1);

    // youngest of two same-address stores wins; memory sees FIFO order
    dm_ready = 1'b0;
    do_store(32'h0000_0080, 32'h1111_1111, 1'b1);
    do_store(32'h0000_0080, 32'h2222_2222, 1'b1);
    do_load(32'h0000_0080, LD_WORD, 1'b1, 1'b0, 32'h2222_2222);
    wait_drain();

    // steady enqueue+drain with one entry resident, crossing the pointer wrap
    dm_ready = 1'b1;
    do_store(32'h0000_0100, 32'hC000_0000, 1'b1);
    for (int i = 1; i <= 2 * DEPTH; i++) begin
      do_store(32'h0000_0100 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b1);
      chk("wrap_not_empty", {31'b0, empty}, 32'd0);
      chk("wrap_st_ready", {31'b0, st_ready}, 32'd1);
      chk("wrap_head_data", dm_writeData, 32'hC000_0000 + 32'(i));
    end
    wait_drain();

    step();
    step();
    chk("wr_queue_left", 32'(exp_wr.size()), 32'd0);
    chk("ld_queue_left", 32'(exp_ld.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
